// File: rtl/prog_loader.sv
// prog_loader: writes a program image into the 16-byte RAM before the CPU runs.
// Each byte taken over the valid/ready handshake produces two bus phases:
// an address phase (MAR write) followed by a data phase (RAM write). pmode
// holds the control unit and step counter frozen for the whole load.
// Optional feature: define PROG_LOADER_VERIFY_EN to add a read-back VERIFY
// phase after every RAM write. A failed compare sets the sticky err flag.
module prog_loader #(
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  output logic              marwa,
  output logic              ramwa,
  output logic              ramoa,
  output logic              ramcs,
  output logic              pmode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCEPT   = 3'd1,
    ST_SET_ADDR = 3'd2,
    ST_WRITE    = 3'd3,
    ST_VERIFY   = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   hold_r;
  logic                last_r;
  logic [ADDR_W:0]     next_count_s;
  logic                last_phase_s;
  logic                mismatch_s;

`ifdef PROG_LOADER_VERIFY_EN
  // Byte completion happens in VERIFY. Read-back is compared against the held byte there.
  always_comb begin
    last_phase_s = (state_r == ST_VERIFY);
    if (state_r == ST_VERIFY) begin
      mismatch_s = (bus_in != hold_r);
    end else begin
      mismatch_s = 1'b0;
    end
  end
`else
  logic unused_bus_s;
  assign unused_bus_s = ^bus_in;

  // Without read-back the byte completes in WRITE and no compare error can occur.
  always_comb begin
    last_phase_s = (state_r == ST_WRITE);
    mismatch_s   = 1'b0;
  end
`endif

  // Byte count after the byte currently in its data phase.
  always_comb begin
    next_count_s = count + (ADDR_W + 1)'(1);
  end

  // FSM, datapath holding registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r  <= ST_IDLE;
      addr_r   <= BASE_A;
      hold_r   <= {DATA_W{1'b0}};
      last_r   <= 1'b0;
      count    <= {(ADDR_W + 1){1'b0}};
      in_ready <= 1'b0;
      bus_out  <= {DATA_W{1'b0}};
      bus_oe   <= 1'b0;
      marwa    <= 1'b0;
      ramwa    <= 1'b0;
      ramoa    <= 1'b0;
      ramcs    <= 1'b0;
      pmode    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Bus strobes and done last one cycle unless the next state re-asserts them.
      bus_out <= {DATA_W{1'b0}};
      bus_oe  <= 1'b0;
      marwa   <= 1'b0;
      ramwa   <= 1'b0;
      ramoa   <= 1'b0;
      ramcs   <= 1'b0;
      done    <= 1'b0;
      if (mismatch_s) begin
        err <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_ACCEPT;
            addr_r   <= BASE_A;
            count    <= {(ADDR_W + 1){1'b0}};
            err      <= 1'b0;
            in_ready <= 1'b1;
            pmode    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_ACCEPT: begin
          if (in_valid && in_ready) begin
            hold_r   <= in_data;
            last_r   <= in_last;
            state_r  <= ST_SET_ADDR;
            in_ready <= 1'b0;
            bus_out  <= DATA_W'(addr_r);
            bus_oe   <= 1'b1;
            marwa    <= 1'b1;
          end
        end
        ST_SET_ADDR: begin
          state_r <= ST_WRITE;
          bus_out <= hold_r;
          bus_oe  <= 1'b1;
          ramcs   <= 1'b1;
          ramwa   <= 1'b1;
        end
        ST_WRITE, ST_VERIFY: begin
          if (last_phase_s) begin
            count  <= next_count_s;
            addr_r <= addr_r + ADDR_W'(1);
            if (last_r) begin
              state_r <= ST_FINISH;
              done    <= 1'b1;
            end else if (next_count_s == DEPTH_C) begin
              // RAM full without a last marker: stop and flag the overflow.
              state_r <= ST_FINISH;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              state_r  <= ST_ACCEPT;
              in_ready <= 1'b1;
            end
          end else begin
            state_r <= ST_VERIFY;
            ramcs   <= 1'b1;
            ramoa   <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          pmode   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b0;
          pmode    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader. Two instances share every
// input: instance 0 uses BASE_ADDR=0 and instance 1 uses BASE_ADDR=14, which
// exercises the address wrap. Each instance has its own MAR/RAM model.
// Load scenarios come from a vector table. Reset, clr mid-load and the
// read-back corruption case are hand-written sequences.
`timescale 1ns/1ps
module tb_prog_loader;

`ifdef PROG_LOADER_VERIFY_EN
  localparam int CPB = 4;
`else
  localparam int CPB = 3;
`endif

  logic       clk = 1'b0;
  logic       clr, start, in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready [2], bus_oe [2], marwa [2], ramwa [2], ramoa [2], ramcs [2];
  logic       pmode [2], busy [2], done [2], err [2];
  logic [7:0] bus_out [2], bus_in [2];
  logic [4:0] count [2];

  logic [3:0] mar [2];
  logic [7:0] mem [2][16];
  int         nwr [2];
  logic       log_clr, corrupt, mon_en;
  int         viol = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    prog_loader #(.ADDR_W(4), .DEPTH(16), .DATA_W(8), .BASE_ADDR(g == 0 ? 0 : 14)) u_dut (
      .clk(clk), .clr(clr), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready[g]), .bus_out(bus_out[g]), .bus_oe(bus_oe[g]),
      .bus_in(bus_in[g]), .marwa(marwa[g]), .ramwa(ramwa[g]), .ramoa(ramoa[g]),
      .ramcs(ramcs[g]), .pmode(pmode[g]), .busy(busy[g]), .done(done[g]), .err(err[g]),
      .count(count[g]));
    assign bus_in[g] = (ramcs[g] && ramoa[g]) ?
                       ((corrupt && mar[g] == 4'd1) ? 8'hFF : mem[g][mar[g]]) : 8'h00;
  end

  // MAR/RAM model: latches the address on marwa, stores the bus on ramcs&ramwa.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (log_clr) begin
        nwr[g] <= 0;
        for (int a = 0; a < 16; a++) mem[g][a] <= 8'hEE;
      end else begin
        if (marwa[g]) mar[g] <= bus_out[g][3:0];
        if (ramcs[g] && ramwa[g]) begin
          mem[g][mar[g]] <= bus_out[g];
          nwr[g] <= nwr[g] + 1;
        end
      end
    end
  end

  // Cycle-by-cycle bus invariants, summarised in one check at the end.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 2; g++) begin
        if ((marwa[g] && ramwa[g]) || (bus_oe[g] && !(marwa[g] || ramwa[g])) ||
            (ramoa[g] && bus_oe[g]) || (pmode[g] !== busy[g]))
          viol++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] dbyte(input int i, input logic [7:0] salt);
    return 8'((i + 1) * 17) ^ salt;
  endfunction

  // One complete load, then timing, status, RAM contents and post-load checks.
  task automatic run_load(input string nm, input int nb, input bit has_last, input int gap,
                          input logic [7:0] salt, input int exp_cnt,
                          input bit exp_err0, input bit exp_err1);
    int sent, stall, edges, lat, base;
    bit rdy_prev, ee;
    sent = 0; stall = gap; edges = 0; lat = -1; rdy_prev = 1'b0;
    @(negedge clk); log_clr = 1'b1;
    @(negedge clk); log_clr = 1'b0;
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); edges = 1;
    while (edges < 300) begin
      @(negedge clk);
      start = 1'b0;
      if (done[0]) begin
        lat = edges;
        break;
      end
      if (in_valid && rdy_prev) begin
        sent++;
        stall = gap;
      end
      if (sent < nb && stall == 0) begin
        in_valid = 1'b1;
        in_data  = dbyte(sent, salt);
        in_last  = has_last && (sent == nb - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (stall > 0 && in_ready[0]) stall--;
      end
      rdy_prev = in_ready[0];
      @(posedge clk); edges++;
    end
    // FINISH is entered 1 + bytes*(cycles per byte) edges after start is sampled.
    chk($sformatf("%s latency", nm), lat, 1 + exp_cnt * (CPB + gap));
    for (int g = 0; g < 2; g++) begin
      ee = (g == 0) ? exp_err0 : exp_err1;
      chk($sformatf("%s count%0d", nm, g), count[g], exp_cnt);
      chk($sformatf("%s err%0d", nm, g), err[g], ee);
      chk($sformatf("%s pmode_fin%0d", nm, g), pmode[g], 1);
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s done_pulse%0d", nm, g), done[g], 0);
      chk($sformatf("%s pmode_idle%0d", nm, g), pmode[g], 0);
      chk($sformatf("%s busy_idle%0d", nm, g), busy[g], 0);
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ee = (g == 0) ? exp_err0 : exp_err1;
      base = (g == 0) ? 0 : 14;
      chk($sformatf("%s ready_after%0d", nm, g), in_ready[g], 0);
      chk($sformatf("%s err_sticky%0d", nm, g), err[g], ee);
      chk($sformatf("%s writes%0d", nm, g), nwr[g], exp_cnt);
      for (int i = 0; i < exp_cnt; i++)
        chk($sformatf("%s ram%0d[%0d]", nm, g, (base + i) % 16), mem[g][(base + i) % 16],
            dbyte(i, salt));
      if (exp_cnt < 16)
        chk($sformatf("%s untouched%0d", nm, g), mem[g][(base + exp_cnt) % 16], 8'hEE);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  typedef struct {
    int nb;
    bit last;
    int gap;
    int exp_cnt;
    bit exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int  sent;
    bit  rdy_prev, found;
    vecs[0] = '{3,  1'b1, 0, 3,  1'b0};
    vecs[1] = '{1,  1'b1, 0, 1,  1'b0};
    vecs[2] = '{2,  1'b1, 2, 2,  1'b0};
    vecs[3] = '{17, 1'b0, 0, 16, 1'b1};
    vecs[4] = '{16, 1'b1, 0, 16, 1'b0};
    vecs[5] = '{4,  1'b1, 1, 4,  1'b0};

    clr = 1'b1; log_clr = 1'b1; corrupt = 1'b0; mon_en = 1'b0;
    start = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 8'hA5;

    // Reset with random inputs: every output zero and start ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        chk($sformatf("reset outputs%0d cyc%0d", g, k),
            {in_ready[g], bus_out[g], bus_oe[g], marwa[g], ramwa[g], ramoa[g], ramcs[g],
             pmode[g], busy[g], done[g], err[g], count[g]}, 0);
      start    = (k == 2) ? 1'b1 : 1'($urandom);
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    clr = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; log_clr = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    chk("start_during_clr busy", busy[0], 0);
    chk("start_during_clr pmode", pmode[0], 0);

    for (int r = 0; r < 6; r++)
      run_load($sformatf("vec%0d", r), vecs[r].nb, vecs[r].last, vecs[r].gap,
               8'(r * 37), vecs[r].exp_cnt, vecs[r].exp_err, vecs[r].exp_err);

    // clr during the data phase of the second byte.
    @(negedge clk); log_clr = 1'b1;
    @(negedge clk); log_clr = 1'b0;
    start = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = dbyte(0, 8'h00);
    sent = 0; rdy_prev = 1'b0; found = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ramwa[0] && nwr[0] == 1) begin
        found = 1'b1;
        break;
      end
      if (in_valid && rdy_prev) sent++;
      in_data  = dbyte(sent, 8'h00);
      rdy_prev = in_ready[0];
      @(posedge clk);
    end
    chk("midclr reached_write2", found, 1);
    clr = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    chk("midclr pmode", pmode[0], 0);
    chk("midclr ramwa", ramwa[0], 0);
    chk("midclr bus_oe", bus_oe[0], 0);
    chk("midclr busy", busy[0], 0);
    chk("midclr count", count[0], 0);
    chk("midclr ram0", mem[0][0], dbyte(0, 8'h00));
    chk("midclr ram14", mem[1][14], dbyte(0, 8'h00));
    run_load("reload", 3, 1'b1, 0, 8'h00, 3, 1'b0, 1'b0);

`ifdef PROG_LOADER_VERIFY_EN
    // Read-back of address 1 is corrupted: instance 0 flags err but finishes.
    corrupt = 1'b1;
    run_load("verify", 3, 1'b1, 0, 8'h5A, 3, 1'b1, 1'b0);
    corrupt = 1'b0;
`endif

    chk("bus invariants", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
